// File: rtl/softusb_mtimer.sv
// rtl/softusb_mtimer.sv - multi-channel prescaled timer with compare flags on the navre IO bus
module softusb_mtimer #(
  parameter logic [5:0] base_addr = 6'h00,
  parameter int         cnt_width = 32,
  parameter int         nchan     = 2
) (
  input  logic             usb_clk,
  input  logic             usb_rst,
  input  logic             io_re,
  input  logic             io_we,
  input  logic [5:0]       io_a,
  input  logic [7:0]       io_di,
  output logic [7:0]       io_do,
  output logic             irq,
  output logic [nchan-1:0] match
);

  localparam int nbytes = cnt_width / 8;
  localparam int win    = 8 + 4 * nchan;

  logic [cnt_width-1:0] r_cnt;
  logic [cnt_width-1:0] r_snap;
  logic [cnt_width-1:0] r_cmp [nchan];
  logic [7:0]           r_pcnt;
  logic [7:0]           r_pre;
  logic [1:0]           r_ctrl;
  logic [nchan-1:0]     r_status;
  logic [nchan-1:0]     r_mask;
  logic [nchan-1:0]     r_match;
  logic [7:0]           r_do;
  logic                 r_irq;

  logic [5:0]           w_off;
  logic                 w_sel;
  logic                 w_wr;
  logic                 w_cnt_wr;
  logic                 w_pre_wr;
  logic                 w_pre_hit;
  logic                 w_tick;
  logic [cnt_width-1:0] w_cnt_next;
  logic [nchan-1:0]     w_hit;
  logic [nchan-1:0]     w_clr;
  logic [7:0]           w_rdata;

  function automatic logic [7:0] byte_of(input logic [cnt_width-1:0] v, input logic [1:0] b);
    logic [31:0] v32;
    v32 = 32'(v);
    return v32[{b, 3'b000} +: 8];
  endfunction

  assign w_off      = io_a - base_addr;
  assign w_sel      = (io_a >= base_addr) && (w_off < 6'(win));
  assign w_wr       = io_we && w_sel;
  assign w_cnt_wr   = w_wr && (w_off[5:2] == 4'd0);
  assign w_pre_wr   = w_wr && (w_off == 6'd4);
  assign w_pre_hit  = (r_pcnt == r_pre);
  // A counter write suppresses the tick, so it also suppresses that tick's matches.
  assign w_tick     = r_ctrl[0] && w_pre_hit && !w_cnt_wr;
  assign w_cnt_next = (r_ctrl[1] && (r_cnt == r_cmp[0])) ? '0 : r_cnt + cnt_width'(1);
  assign w_clr      = (w_wr && (w_off == 6'd6)) ? io_di[nchan-1:0] : '0;

  always_comb begin
    w_hit = '0;
    for (int c = 0; c < nchan; c++) begin
      w_hit[c] = w_tick && (w_cnt_next == r_cmp[c]);
    end
  end

  // Byte 0 is live; bytes 1..3 come from the snapshot taken on a byte-0 read.
  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        6'd0:             w_rdata = byte_of(r_cnt, 2'd0);
        6'd1, 6'd2, 6'd3: w_rdata = byte_of(r_snap, w_off[1:0]);
        6'd4:             w_rdata = r_pre;
        6'd5:             w_rdata = {6'd0, r_ctrl};
        6'd6:             w_rdata = 8'(r_status);
        6'd7:             w_rdata = 8'(r_mask);
        default: begin
          for (int c = 0; c < nchan; c++) begin
            if (w_off[4:2] == 3'(c + 2)) w_rdata = byte_of(r_cmp[c], w_off[1:0]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge usb_clk or posedge usb_rst) begin
    if (usb_rst) begin
      r_cnt    <= '0;
      r_snap   <= '0;
      r_pcnt   <= '0;
      r_pre    <= '0;
      r_ctrl   <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_match  <= '0;
      r_do     <= '0;
      r_irq    <= 1'b0;
      for (int c = 0; c < nchan; c++) r_cmp[c] <= '0;
    end else begin
      if (io_re && w_sel && (w_off == 6'd0)) r_snap <= r_cnt;

      if (w_cnt_wr) begin
        r_cnt  <= '0;
        r_pcnt <= '0;
      end else begin
        if (w_tick) r_cnt <= w_cnt_next;
        if (w_pre_wr)       r_pcnt <= '0;
        else if (r_ctrl[0]) r_pcnt <= w_pre_hit ? 8'd0 : r_pcnt + 8'd1;
      end

      if (w_pre_wr) r_pre <= io_di;
      if (w_wr && (w_off == 6'd5)) r_ctrl <= io_di[1:0];
      if (w_wr && (w_off == 6'd7)) r_mask <= io_di[nchan-1:0];

      for (int c = 0; c < nchan; c++) begin
        for (int j = 0; j < nbytes; j++) begin
          if (w_wr && (w_off == 6'(8 + 4 * c + j))) r_cmp[c][8*j +: 8] <= io_di;
        end
      end

      // A flag set on the same edge as its W1C clear stays set.
      r_status <= (r_status & ~w_clr) | w_hit;
      r_match  <= w_hit;
      r_irq    <= |(r_status & r_mask);
      r_do     <= w_rdata;
    end
  end

  assign io_do = r_do;
  assign irq   = r_irq;
  assign match = r_match;

endmodule

// File: tb/tb_softusb_mtimer.sv
// tb/tb_softusb_mtimer.sv - directed vector bench for softusb_mtimer (32-bit/2ch at 0x00, 8-bit/2ch at 0x20)
module tb_softusb_mtimer;

  logic       usb_clk = 1'b0;
  logic       usb_rst = 1'b1;
  logic       io_re   = 1'b0;
  logic       io_we   = 1'b0;
  logic [5:0] io_a    = '0;
  logic [7:0] io_di   = '0;
  logic [7:0] io_do_a, io_do_b;
  logic       irq_a, irq_b;
  logic [1:0] match_a, match_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 usb_clk = ~usb_clk;

  softusb_mtimer #(.base_addr(6'h00), .cnt_width(32), .nchan(2)) u_a (
    .usb_clk(usb_clk), .usb_rst(usb_rst), .io_re(io_re), .io_we(io_we),
    .io_a(io_a), .io_di(io_di), .io_do(io_do_a), .irq(irq_a), .match(match_a)
  );

  softusb_mtimer #(.base_addr(6'h20), .cnt_width(8), .nchan(2)) u_b (
    .usb_clk(usb_clk), .usb_rst(usb_rst), .io_re(io_re), .io_we(io_we),
    .io_a(io_a), .io_di(io_di), .io_do(io_do_b), .irq(irq_b), .match(match_b)
  );

  typedef struct {
    logic       we;
    logic [5:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic we, input logic [5:0] a, input logic [7:0] d, input logic [7:0] exp);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge usb_clk);
    io_we = 1'b1; io_a = a; io_di = d;
    @(negedge usb_clk);
    io_we = 1'b0; io_di = '0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge usb_clk);
    io_re = 1'b1; io_a = a;
    @(negedge usb_clk);
    io_re = 1'b0;
    d = io_do_a | io_do_b;
  endtask

  logic [7:0] got;

  initial begin
    // reset state and static register semantics
    for (int i = 0; i < 8; i++) add(1'b0, 6'(i), 8'h00, 8'h00);
    add(1'b0, 6'h3F, 8'h00, 8'h00);
    add(1'b0, 6'h20, 8'h00, 8'h00);
    add(1'b0, 6'h27, 8'h00, 8'h00);
    add(1'b1, 6'h04, 8'h5A, 8'h00); add(1'b0, 6'h04, 8'h00, 8'h5A);
    add(1'b1, 6'h05, 8'hFE, 8'h00); add(1'b0, 6'h05, 8'h00, 8'h02);
    add(1'b1, 6'h07, 8'hFF, 8'h00); add(1'b0, 6'h07, 8'h00, 8'h03);
    add(1'b1, 6'h08, 8'h11, 8'h00); add(1'b1, 6'h09, 8'h22, 8'h00);
    add(1'b1, 6'h0A, 8'h33, 8'h00); add(1'b1, 6'h0B, 8'h44, 8'h00);
    add(1'b0, 6'h08, 8'h00, 8'h11); add(1'b0, 6'h0B, 8'h00, 8'h44);
    add(1'b1, 6'h0C, 8'h77, 8'h00); add(1'b0, 6'h0C, 8'h00, 8'h77);
    add(1'b0, 6'h0D, 8'h00, 8'h00);
    add(1'b1, 6'h29, 8'h55, 8'h00); add(1'b0, 6'h29, 8'h00, 8'h00);
    add(1'b1, 6'h28, 8'h66, 8'h00); add(1'b0, 6'h28, 8'h00, 8'h66);
    add(1'b1, 6'h3F, 8'hFF, 8'h00); add(1'b0, 6'h3F, 8'h00, 8'h00);
    add(1'b1, 6'h27, 8'hFF, 8'h00); add(1'b0, 6'h27, 8'h00, 8'h03);
    add(1'b1, 6'h06, 8'hFF, 8'h00); add(1'b0, 6'h06, 8'h00, 8'h00);
    add(1'b0, 6'h00, 8'h00, 8'h00);
    add(1'b1, 6'h05, 8'h00, 8'h00); add(1'b1, 6'h07, 8'h00, 8'h00);
    add(1'b1, 6'h27, 8'h00, 8'h00); add(1'b1, 6'h04, 8'h00, 8'h00);

    repeat (3) @(negedge usb_clk);
    usb_rst = 1'b0;
    chk("reset irq", {30'd0, irq_b, irq_a}, 32'd0);
    chk("reset match", {28'd0, match_b, match_a}, 32'd0);

    foreach (tbl[i]) begin
      if (tbl[i].we) wr(tbl[i].a, tbl[i].d);
      else begin
        rd(tbl[i].a, got);
        chk($sformatf("vec%0d rd 0x%02h", i, tbl[i].a), got, tbl[i].exp);
      end
    end

    // prescaler PRE=3: one tick every 4 cycles
    wr(6'h04, 8'd3); wr(6'h00, 8'd0); wr(6'h05, 8'd1);
    repeat (40) @(negedge usb_clk);
    rd(6'h00, got); chk("pre3 cnt byte0", got, 8'd10);
    for (int b = 1; b < 4; b++) begin
      rd(6'(b), got); chk($sformatf("pre3 cnt byte%0d", b), got, 8'd0);
    end
    wr(6'h05, 8'd0);

    // snapshot coherence across the 0xFF->0x100 carry
    wr(6'h04, 8'd0); wr(6'h00, 8'd0); wr(6'h05, 8'd1);
    repeat (250) @(negedge usb_clk);
    rd(6'h00, got); chk("snap byte0", got, 8'hFB);
    repeat (10) @(negedge usb_clk);
    rd(6'h01, got); chk("snap byte1 held", got, 8'h00);
    rd(6'h00, got); chk("snap2 byte0", got, 8'h09);
    rd(6'h01, got); chk("snap2 byte1", got, 8'h01);
    rd(6'h02, got); chk("snap2 byte2", got, 8'h00);
    wr(6'h05, 8'd0);

    // period mode CMP0=5: sequence 0..5, match0 every 6 cycles
    wr(6'h08, 8'd5); wr(6'h09, 8'd0); wr(6'h0A, 8'd0); wr(6'h0B, 8'd0);
    wr(6'h06, 8'hFF); wr(6'h00, 8'd0); wr(6'h05, 8'd3);
    io_a = 6'h00;
    for (int k = 1; k <= 18; k++) begin
      @(negedge usb_clk);
      chk($sformatf("period match k%0d", k), match_a, (k % 6 == 5) ? 2'b01 : 2'b00);
      chk($sformatf("period cnt k%0d", k), io_do_a, 8'((k - 1) % 6));
    end
    wr(6'h05, 8'd0);
    rd(6'h06, got); chk("period status", got, 8'h01);
    wr(6'h07, 8'h01);
    repeat (2) @(negedge usb_clk);
    chk("irq masked in", irq_a, 1'b1);
    wr(6'h06, 8'h01);
    chk("irq after w1c +1", irq_a, 1'b1);
    @(negedge usb_clk);
    chk("irq after w1c +2", irq_a, 1'b0);
    wr(6'h07, 8'h00);

    // two channels hit on the same tick; W1C loses to a same-cycle set
    wr(6'h08, 8'd7); wr(6'h0C, 8'd7);
    wr(6'h06, 8'h03); wr(6'h00, 8'd0); wr(6'h05, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge usb_clk);
      chk($sformatf("dual match k%0d", k), match_a, (k == 7) ? 2'b11 : 2'b00);
    end
    rd(6'h06, got); chk("dual status", got, 8'h03);
    wr(6'h05, 8'd0); wr(6'h00, 8'd0); wr(6'h05, 8'd3);
    repeat (13) @(negedge usb_clk);
    wr(6'h06, 8'h03);
    rd(6'h06, got); chk("w1c vs set", got, 8'h03);
    wr(6'h06, 8'h03);
    rd(6'h06, got); chk("w1c plain", got, 8'h00);
    wr(6'h05, 8'd0);

    // counter write on a tick cycle clears counter and restarts prescaler
    wr(6'h04, 8'd2); wr(6'h00, 8'd0); wr(6'h05, 8'd1);
    repeat (7) @(negedge usb_clk);
    wr(6'h01, 8'h00);
    rd(6'h00, got); chk("cntwr on tick", got, 8'd0);
    rd(6'h00, got); chk("cntwr restart", got, 8'd1);
    wr(6'h05, 8'd0);

    // 8-bit instance wraps 0xFF -> 0 and sets flag1 (CMP1=0)
    wr(6'h2C, 8'd0); wr(6'h24, 8'd0); wr(6'h26, 8'hFF); wr(6'h20, 8'd0); wr(6'h25, 8'd1);
    repeat (255) @(negedge usb_clk);
    chk("wrap pre match", match_b, 2'b00);
    @(negedge usb_clk);
    chk("wrap match1", match_b, 2'b10);
    rd(6'h20, got); chk("wrap cnt", got, 8'd1);
    rd(6'h21, got); chk("b byte1 zero", got, 8'd0);
    rd(6'h26, got); chk("wrap status", got, 8'h03);
    wr(6'h25, 8'd0);

    // asynchronous reset while running with flags set
    wr(6'h07, 8'h03); wr(6'h06, 8'h03); wr(6'h04, 8'd0); wr(6'h00, 8'd0); wr(6'h05, 8'd1);
    repeat (10) @(negedge usb_clk);
    chk("pre-rst irq", irq_a, 1'b1);
    chk("pre-rst io_do", io_do_a, 8'h01);
    usb_rst = 1'b1;
    #1;
    chk("async rst io_do", io_do_a, 8'h00);
    chk("async rst irq", irq_a, 1'b0);
    chk("async rst match", match_a, 2'b00);
    @(negedge usb_clk);
    usb_rst = 1'b0;
    repeat (5) @(negedge usb_clk);
    rd(6'h00, got); chk("post-rst cnt", got, 8'd0);
    rd(6'h05, got); chk("post-rst ctrl", got, 8'd0);
    rd(6'h06, got); chk("post-rst status", got, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
